alu_regfile_wb: RTL
===================

Name: alu_regfile_wb

Overview:
- 8-entry x 16-bit register file that sits directly upstream of the 16-bit ALU and closes the loop from ALU output back to ALU operands.
- Two combinational read ports drive ALU inputs a and b; one write-back port accepts ALU result y.
- Write-back is pipelined through a one-entry pending stage with operand forwarding, and zero/negative condition flags are kept for the branch logic.

Parameters:
- WIDTH, 16, data width of registers, operands and write-back data.
- NREG, 8, number of registers.
- AW, 3, register address width; NREG == 2**AW.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ra_addr  in  AW  read port A register select (feeds ALU a).
- rb_addr  in  AW  read port B register select (feeds ALU b).
- a_out  out  WIDTH  read port A data.
- b_out  out  WIDTH  read port B data.
- wb_valid  in  1  write-back request this cycle.
- wb_addr  in  AW  write-back destination register.
- wb_data  in  WIDTH  write-back data (ALU y).
- wb_flag_en  in  1  update flags from wb_data with this write-back; ignored when wb_valid=0.
- flag_z  out  1  zero flag: last flagged write-back data == 0.
- flag_n  out  1  negative flag: bit WIDTH-1 of last flagged write-back data.
- pend_busy  out  1  pending stage holds an uncommitted write.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - rst=1 clears all NREG registers to 0, pend_valid=0, pend_addr=0, pend_data=0, flag_z=0, flag_n=0.
  - Outputs during reset: a_out=b_out=0, pend_busy=0.
  - Reset asserted mid-operation discards any pending write; it is never committed.
- Pipeline, per rising edge when rst=0, in this order:
  1. If pend_valid=1, commit: reg[pend_addr] <= pend_data.
  2. Capture: pend_valid <= wb_valid. If wb_valid=1, pend_addr <= wb_addr and pend_data <= wb_data.
- Write latency:
  - Data is readable via forwarding from the cycle after wb_valid.
  - Data is resident in the array from two edges after wb_valid.
- Back-to-back writes on consecutive cycles are always accepted, no stall. The older write commits on the same edge the newer one is captured.
- Read ports are purely combinational, evaluated independently for A and B with this priority:
  - If pend_valid=1 and addr==pend_addr: pend_data (forwarding).
  - Otherwise: reg[addr].
- No forwarding from the unregistered wb_data input. This prevents a combinational loop through the ALU.
- Both ports may address the same register simultaneously and must return identical data.
- Two successive writes to the same address: the pending entry always holds the newer value, and the array ends with the newer value.
- Flags:
  - On an edge with wb_valid=1 and wb_flag_en=1: flag_z <= (wb_data==0), flag_n <= wb_data[WIDTH-1].
  - Flags are updated at capture, not commit.
  - When wb_valid=0 or wb_flag_en=0, flags hold.
- pend_busy = pend_valid.
- All registers in the array are general-purpose; none is hardwired.
- Addresses are always in range (NREG == 2**AW); no out-of-range handling.

Test Plan:
1. Reset: assert rst with wb_valid=1, wb_addr=3, wb_data=16'h1234 for 3 cycles, then release -> all reads 0, flag_z=0, flag_n=0, pend_busy=0.
2. Single write and forward: wb 16'hFFFE to r2 with flag_en=1 at edge N; set ra_addr=2 -> a_out=16'hFFFE after edge N via pend_busy=1; still 16'hFFFE after edge N+1 with pend_busy=0; flag_n=1, flag_z=0.
3. Back-to-back same address: wb r5=16'h00AA then r5=16'h0055 on consecutive cycles; ra_addr=rb_addr=5 -> both ports show 16'h00AA after first edge, 16'h0055 after second and all later edges.
4. Mixed priority: r1=16'hFF00 resident; wb r4=16'hF0F0 pending; ra_addr=1, rb_addr=4 -> a_out=16'hFF00, b_out=16'hF0F0.
5. Flags: wb 16'h0000 with flag_en=1 -> flag_z=1, flag_n=0. Then wb 16'h8000 with flag_en=0 -> flags unchanged; r-file holds 16'h8000.
6. Reset mid-pipeline: wb r7=16'hFFF0, assert rst asynchronously before the next edge -> r7 reads 0 after release, pend_busy=0.

Source files
------------

// File: rtl/alu_regfile_wb.sv
// 8 x 16-bit register file between ALU result and ALU operands.
// Write-back passes through a one-entry pending stage that forwards to both read ports.
module alu_regfile_wb #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra_addr,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             wb_flag_en,
    output logic             flag_z,
    output logic             flag_n,
    output logic             pend_busy
);

    logic [WIDTH-1:0] regs [NREG];
    logic             pend_valid;
    logic [AW-1:0]    pend_addr;
    logic [WIDTH-1:0] pend_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (pend_valid) begin
            regs[pend_addr] <= pend_data;
        end
    end

    // The older write commits on the same edge the newer one is captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
        end else begin
            pend_valid <= wb_valid;
            if (wb_valid) begin
                pend_addr <= wb_addr;
                pend_data <= wb_data;
            end
        end
    end

    // Flags follow the captured write-back, not the commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (wb_valid && wb_flag_en) begin
            flag_z <= (wb_data == '0);
            flag_n <= wb_data[WIDTH-1];
        end
    end

    // Forward only from the registered pending entry; wb_data is never a read source.
    always_comb begin
        a_out = regs[ra_addr];
        b_out = regs[rb_addr];
        if (pend_valid && (ra_addr == pend_addr)) a_out = pend_data;
        if (pend_valid && (rb_addr == pend_addr)) b_out = pend_data;
    end

    assign pend_busy = pend_valid;

endmodule
